// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// valid/ready handshakes, sticky overflow with 9s saturation and a leading-zero blank mask.
module seq_bin_to_bcd #(
    parameter int BIN_W  = 9,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    in_bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]   out_blank,
    output logic                overflow
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg, state_next;
    logic [BIN_W-1:0]   shreg_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic               ovf_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_next;
    logic               ovf_next;
    logic [DIGITS-1:0]  blank_next;
    logic               last_step;

    // Per-digit add-3 correction and leading-zero detection on the post-shift value
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                             : bcd_reg[4*gi +: 4];
        if (gi == 0) begin : g_units
            assign blank_next[gi] = 1'b0;
        end else begin : g_upper
            assign blank_next[gi] = ~|bcd_next[BCD_W-1:4*gi];
        end
    end

    assign bcd_next  = {adj[BCD_W-2:0], shreg_reg[BIN_W-1]};
    // Anything shifted out of the top digit means the value needs more digits than we have
    assign ovf_next  = ovf_reg | adj[BCD_W-1];
    assign last_step = (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg <= '0;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            out_bcd   <= '0;
            out_blank <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shreg_reg <= in_bin;
                        bcd_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        cnt_reg   <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    shreg_reg <= shreg_reg << 1;
                    bcd_reg   <= bcd_next;
                    ovf_reg   <= ovf_next;
                    cnt_reg   <= cnt_reg - CNT_W'(1);
                    if (last_step) begin
                        out_bcd   <= ovf_next ? ALL_NINES : bcd_next;
                        out_blank <= ovf_next ? '0 : blank_next;
                        overflow  <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Directed bench for seq_bin_to_bcd: a 9-bit and a 10-bit instance (3 digits each),
// scoreboard of expected results filled on accept and drained when out_valid rises.
module tb_seq_bin_to_bcd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        overflow  [2];
    logic [11:0] out_bcd   [2];
    logic [2:0]  out_blank [2];
    logic [8:0]  in_bin9;
    logic [9:0]  in_bin10;

    seq_bin_to_bcd #(.BIN_W(9), .DIGITS(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bin(in_bin9),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bcd(out_bcd[0]), .out_blank(out_blank[0]), .overflow(overflow[0])
    );

    seq_bin_to_bcd #(.BIN_W(10), .DIGITS(3)) dut10 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bin(in_bin10),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bcd(out_bcd[1]), .out_blank(out_blank[1]), .overflow(overflow[1])
    );

    typedef struct {
        logic [11:0] bcd;
        logic [2:0]  blank;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t_acc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference computed by division, saturating at 999
    function automatic exp_t model(input int v);
        exp_t e;
        int d2, d1, d0;
        if (v >= 1000) begin
            e.bcd   = 12'h999;
            e.blank = 3'b000;
            e.ovf   = 1'b1;
        end else begin
            d2 = v / 100;
            d1 = (v / 10) % 10;
            d0 = v % 10;
            e.bcd   = {d2[3:0], d1[3:0], d0[3:0]};
            e.blank = {d2 == 0, (d2 == 0) && (d1 == 0), 1'b0};
            e.ovf   = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int sel, input int v, input bit push);
        int n = 0;
        @(negedge clk);
        in_valid[sel] = 1'b1;
        if (sel == 0) in_bin9 = 9'(v); else in_bin10 = 10'(v);
        while (!in_ready[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        t_acc = cyc;
        in_valid[sel] = 1'b0;
        // Scramble the input after acceptance: it must not be re-sampled
        in_bin9  = 9'($urandom);
        in_bin10 = 10'($urandom);
        if (push) sb.push_back(model(v));
    endtask

    task automatic collect(input int sel, input string tag);
        int   n  = 0;
        int   bw = (sel == 0) ? 9 : 10;
        exp_t e;
        @(negedge clk);
        check({tag, "_busy"}, 32'(in_ready[sel]), 32'd0);
        while (!out_valid[sel] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(cyc - t_acc), 32'(bw));
        e = sb.pop_front();
        check({tag, "_bcd"}, 32'(out_bcd[sel]), 32'(e.bcd));
        check({tag, "_blank"}, 32'(out_blank[sel]), 32'(e.blank));
        check({tag, "_ovf"}, 32'(overflow[sel]), 32'(e.ovf));
        $display("txn inst=%0d bcd=%h blank=%b ovf=%b", sel, out_bcd[sel], out_blank[sel], overflow[sel]);
    endtask

    task automatic convert(input int sel, input int v, input string tag);
        send(sel, v, 1'b1);
        collect(sel, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_bin9 = '0;
        in_bin10 = '0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_state", {out_valid[i], in_ready[i], out_bcd[i], out_blank[i], overflow[i]},
                  {1'b0, 1'b1, 12'h000, 3'b000, 1'b0});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        convert(0, 255, "v255");
        convert(0, 0,   "v0");
        convert(0, 7,   "v7");
        convert(0, 300, "v300");
        convert(0, 511, "v511");

        convert(1, 1000, "w1000");
        convert(1, 999,  "w999");
        convert(1, 1023, "w1023");
        convert(1, 0,    "w0");

        // Backpressure: result held while out_ready is low, new inputs ignored
        out_ready[0] = 1'b0;
        send(0, 255, 1'b1);
        collect(0, "bp");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid[0] = i[0];
            in_bin9 = 9'd5;
            check("bp_hold", {out_valid[0], in_ready[0], out_bcd[0], out_blank[0], overflow[0]},
                  {1'b1, 1'b0, 12'h255, 3'b000, 1'b0});
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release", {out_valid[0], in_ready[0], out_bcd[0]}, {1'b0, 1'b1, 12'h255});

        for (int v = 0; v < 512; v++) convert(0, v, "sweep");

        // Reset in the middle of converting 123
        send(0, 123, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset", {out_valid[0], in_ready[0], out_bcd[0], out_blank[0], overflow[0]},
              {1'b0, 1'b1, 12'h000, 3'b000, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        convert(0, 42, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
